// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: result-source handshake and Common Data Bus broadcast bundle.
//   src_valid/src_data/src_tag : per-source result offer (master -> arbiter)
//   src_ready                  : per-source holding buffer can accept (arbiter -> master)
//   cdb_valid/cdb_data/cdb_tag/cdb_src : registered broadcast (arbiter -> consumers)
interface cdb_arbiter_if #(
    parameter int N_SRC  = 6,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int SRC_W  = $clog2(N_SRC)
);
    logic [N_SRC-1:0]        src_valid;
    logic [N_SRC*DATA_W-1:0] src_data;
    logic [N_SRC*TAG_W-1:0]  src_tag;
    logic [N_SRC-1:0]        src_ready;
    logic [DATA_W-1:0]       cdb_data;
    logic [TAG_W-1:0]        cdb_tag;
    logic                    cdb_valid;
    logic [SRC_W-1:0]        cdb_src;

    modport master (
        output src_valid, src_data, src_tag,
        input  src_ready, cdb_data, cdb_tag, cdb_valid, cdb_src
    );

    modport slave (
        input  src_valid, src_data, src_tag,
        output src_ready, cdb_data, cdb_tag, cdb_valid, cdb_src
    );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter granting one-entry result buffers onto a registered CDB.
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   flush_i : synchronous clear of all pending results and the round-robin pointer
//   bus     : slave side of cdb_arbiter_if (source handshakes in, CDB broadcast out)
module cdb_arbiter #(
    parameter int N_SRC  = 6,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    cdb_arbiter_if.slave bus
);
    localparam int SRC_W = $clog2(N_SRC);

    logic [N_SRC-1:0]  full_q, full_d, grant, accept;
    logic [DATA_W-1:0] data_q [N_SRC];
    logic [DATA_W-1:0] data_d [N_SRC];
    logic [TAG_W-1:0]  tag_q  [N_SRC];
    logic [TAG_W-1:0]  tag_d  [N_SRC];
    logic [SRC_W-1:0]  ptr_q, ptr_d, gnt_idx, idx;
    logic              gnt_any;
    logic              cdb_valid_q, cdb_valid_d;
    logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
    logic [TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [SRC_W-1:0]  cdb_src_q, cdb_src_d;

    // First full buffer at or after ptr (wrapping) wins; flush suppresses the grant.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = SRC_W'((int'(ptr_q) + k) % N_SRC);
            if (!gnt_any && full_q[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt_any = gnt_any & ~flush_i;
        grant   = gnt_any ? (N_SRC'(1) << gnt_idx) : '0;
    end

    // A buffer being granted this cycle can be refilled on the same edge.
    assign bus.src_ready = {N_SRC{~flush_i}} & (~full_q | grant);
    assign accept        = bus.src_valid & bus.src_ready;

    always_comb begin
        full_d      = full_q;
        data_d      = data_q;
        tag_d       = tag_q;
        ptr_d       = ptr_q;
        cdb_valid_d = gnt_any;
        cdb_data_d  = cdb_data_q;
        cdb_tag_d   = cdb_tag_q;
        cdb_src_d   = cdb_src_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (accept[i]) begin
                full_d[i] = 1'b1;
                data_d[i] = bus.src_data[i*DATA_W +: DATA_W];
                tag_d[i]  = bus.src_tag[i*TAG_W +: TAG_W];
            end else if (grant[i]) begin
                full_d[i] = 1'b0;
            end
        end
        if (gnt_any) begin
            ptr_d      = (gnt_idx == SRC_W'(N_SRC - 1)) ? '0 : gnt_idx + 1'b1;
            cdb_data_d = data_q[gnt_idx];
            cdb_tag_d  = tag_q[gnt_idx];
            cdb_src_d  = gnt_idx;
        end
        // Accepts and grants are already blocked while flushing; only state needs clearing.
        if (flush_i) begin
            full_d = '0;
            ptr_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q      <= '0;
            ptr_q       <= '0;
            cdb_valid_q <= 1'b0;
            cdb_data_q  <= '0;
            cdb_tag_q   <= '0;
            cdb_src_q   <= '0;
            for (int i = 0; i < N_SRC; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            full_q      <= full_d;
            ptr_q       <= ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_data_q  <= cdb_data_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_src_q   <= cdb_src_d;
            data_q      <= data_d;
            tag_q       <= tag_d;
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_data  = cdb_data_q;
    assign bus.cdb_tag   = cdb_tag_q;
    assign bus.cdb_src   = cdb_src_q;
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Registered round-robin arbiter for the Common Data Bus. Each producing functional unit (three adders, two multipliers, memory) hands its result to a one-entry holding buffer through a valid/ready handshake, which frees the unit immediately. The arbiter then grants one occupied buffer per cycle in round-robin order and drives a registered broadcast (`cdb_data`/`cdb_tag`/`cdb_valid`) to the reservation stations and register file. Every source is guaranteed forward progress, and no result is lost when several units finish in the same cycle.

## Interface
- `N_SRC`, 6, number of result sources; index 0-2 adders, 3-4 multipliers, 5 memory
- `DATA_W`, 32, result data width
- `TAG_W`, 4, reservation-station tag width
- `clk` input 1: single clock; all state updates on the rising edge
- `rst_n` input 1: reset, asynchronous and active-low
- `flush` input 1: synchronous clear of all pending results
- `src_valid` input N_SRC: source i presents a result
- `src_data` input N_SRC*DATA_W: source i data in bits [i*DATA_W +: DATA_W]
- `src_tag` input N_SRC*TAG_W: source i tag in bits [i*TAG_W +: TAG_W]
- `src_ready` output N_SRC: buffer i can accept this cycle
- `cdb_data` output DATA_W: broadcast data (registered)
- `cdb_tag` output TAG_W: broadcast tag (registered)
- `cdb_valid` output 1: broadcast valid (registered)
- `cdb_src` output $clog2(N_SRC): index of the source being broadcast (registered)

## Operation
- **Per-source buffer state:** `full[i]`, `buf_data[i]`, `buf_tag[i]`.
- **Handshake:**
  - A transfer occurs on an edge where `src_valid[i] & src_ready[i]`.
  - `src_ready[i] = ~flush & (~full[i] | grant[i])`. This is combinational, so the buffer refills in the same cycle it is granted.
  - A source must hold data and tag stable while valid and not ready.
- **Arbitration (combinational, on `full`):**
  - Search starts at pointer `ptr` and proceeds ascending, modulo N_SRC.
  - The first full buffer found gets `grant[i]`.
  - At most one grant per cycle.
  - Grants are suppressed during `flush`.
- **Pointer update:**
  - On a grant to i: `ptr <= (i+1) mod N_SRC`.
  - No grant: `ptr` unchanged.
- **Buffer update per edge, for each i:**
  - Accept takes priority: load data/tag, set `full`.
  - Else if granted: clear `full`.
  - Else hold.
- **Output register:**
  - On a grant: `cdb_valid <= 1`, and `cdb_data`/`cdb_tag`/`cdb_src` load from buffer i.
  - Otherwise `cdb_valid <= 0`, and data/tag/src hold their previous values.
- **Flush:**
  - On the next edge, all `full` clear, `cdb_valid <= 0` and `ptr <= 0`.
  - No accepts and no grants occur in the flush cycle.
  - `cdb_data`/`cdb_tag`/`cdb_src` hold.
- **Tags** are passed through unchecked. No deduplication, and tag 0 is not special.

## Timing
- **Reset** (`rst_n` low, asynchronous, immediate):
  - Registers: all `full`=0, `ptr`=0, `cdb_valid`=0, `cdb_data`=0, `cdb_tag`=0, `cdb_src`=0, buffers 0.
  - `src_ready` = all 1 once `rst_n` is high, provided `flush`=0.
- **Latency:**
  - Handshake at edge E gives `full` in the cycle after E.
  - Earliest `cdb_valid` is in the cycle after the next edge, i.e. 2 cycles from acceptance.
- **Throughput:**
  - One broadcast per cycle overall.
  - A lone source that is continuously valid achieves 1 result/cycle (grant and refill in the same cycle).
- **Boundaries:**
  - Buffer full and not granted: `src_ready[i]`=0 and the source stalls.
  - Wrap-around: with `ptr`=N_SRC-1, the search order is N_SRC-1, 0, 1, ...
  - With all N_SRC buffers full, draining takes exactly N_SRC consecutive cycles in pointer order. No source waits more than N_SRC-1 grants.
  - Simultaneous grant and accept on the same buffer: new data is stored and `full` stays 1.
  - Reset mid-operation discards all buffered and broadcast results.

## Test plan
- **Reset:** assert `rst_n`=0 mid-traffic with buffers full. Required: all outputs 0 immediately. After release, `src_ready`=6'b111111 and `cdb_valid`=0.
- **Single result:** source 3, data 0x0000_00AB, tag 4'h7, accepted at edge E. Required: `cdb_valid`=1 with `cdb_data`=0xAB, `cdb_tag`=7, `cdb_src`=3 exactly 2 cycles later, for one cycle only.
- **Simultaneous burst:** all six sources valid for one cycle from reset (`ptr`=0), tags 1..6. Required: broadcasts with tags 1,2,3,4,5,6 on six consecutive cycles, no gaps, then `cdb_valid`=0. `src_ready[i]`=0 until buffer i is granted.
- **Fairness:** sources 0 and 5 continuously valid. Required: `cdb_src` alternates 0,5,0,5... and neither is skipped.
- **Streaming:** source 1 alone valid for 8 cycles with data 1..8. Required: `src_ready[1]` stays 1 and data 1..8 broadcasts on 8 consecutive cycles.
- **Flush:** 4 buffers full and `flush` pulsed for one cycle. Required: `src_ready`=0 during the pulse, no broadcasts afterwards, `ptr`=0, and the next accepted result broadcasts 2 cycles later.
